sum_window_acc: RTL and testbench
=================================

SUM_WINDOW_ACC -- requirements
Module: sum_window_acc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the clock port named clk and the reset port named rst.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of each input sample (the adder-stage sum).
REQ-003 Parameter LEN_W, default 4, SHALL set the width of the window-length field; maximum window = 2^LEN_W samples.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_data  input  DATA_W  unsigned sample from the adder stage.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 cfg_len  input  LEN_W  window length; 0 means 2^LEN_W.
REQ-010 flush  input  1  single-cycle request to emit a partial window.
REQ-011 out_valid  output  1  window result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sum  output  DATA_W+LEN_W+1  unsigned window total.
REQ-014 out_count  output  LEN_W+1  number of samples in the emitted window.

Function
REQ-015 The FSM SHALL have exactly two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A sample SHALL be accepted when in_valid && in_ready, adding in_data to acc and incrementing cnt.
REQ-017 cfg_len SHALL be latched when the first sample of a window is accepted (cnt==0), and SHALL be ignored mid-window.
REQ-018 When the accepted sample makes cnt equal the latched length, the FSM SHALL enter HOLD next cycle, with out_sum/out_count registered (latency 1 cycle).
REQ-019 flush in ACC with cnt>0 SHALL enter HOLD next cycle with the partial result; flush with cnt==0 and no accepted sample SHALL be ignored.
REQ-020 flush coinciding with an accepted sample SHALL include that sample in the emitted result.
REQ-021 flush in HOLD SHALL be ignored.
REQ-022 In HOLD, out_sum/out_count SHALL be stable until out_valid && out_ready; on handshake, acc and cnt SHALL clear and the FSM SHALL return to ACC next cycle.
REQ-023 The accumulator SHALL be DATA_W+LEN_W+1 bits wide, so overflow is impossible; no wrap or saturation logic is required.
REQ-024 in_ready and out_valid SHALL depend only on state, never combinationally on in_valid or out_ready.

Reset
REQ-025 On rst, the FSM SHALL enter ACC, acc=0, cnt=0, latched length=2^LEN_W, out_valid=0, in_ready=1, out_sum=0, out_count=0.
REQ-026 rst asserted mid-window or in HOLD SHALL discard the pending result with no output handshake.

Configuration
REQ-027 With macro SUM_WINDOW_ACC_MAX_EN defined, the block SHALL add output out_max (DATA_W) holding the largest sample of the emitted window, reset to 0 and updated alongside out_sum.
REQ-028 Without SUM_WINDOW_ACC_MAX_EN, out_max and its logic SHALL be absent.

Structure
REQ-029 Package sum_window_acc_pkg SHALL hold the FSM state enum (ACC, HOLD) and default width constants (DATA_W=8, LEN_W=4).
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 cfg_len=4, samples 10,20,30,40 back-to-back, out_ready=1 -> out_valid one cycle after the 4th, out_sum=100, out_count=4, in_ready=1 the cycle after handshake.
REQ-032 cfg_len=0, 16 samples of 255 -> out_sum=4080, out_count=16, no overflow.
REQ-033 cfg_len=8, samples 5,7, then flush alone -> out_sum=12, out_count=2; flush with cnt==0 -> no output.
REQ-034 cfg_len=3, out_ready=0 for 5 cycles after result -> out_sum stable, in_ready=0, in_valid samples not accepted; release -> handshake, return to ACC.
REQ-035 rst asserted after 2 of 4 samples -> out_valid=0, next window of 4 samples of 1 yields out_sum=4.
REQ-036 With SUM_WINDOW_ACC_MAX_EN, cfg_len=3, samples 9,200,3 -> out_max=200, out_sum=212.

Source files
------------

// File: rtl/sum_window_acc_pkg.sv
// Shared types and default widths for the windowed sample accumulator.
package sum_window_acc_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultLenW  = 4;

  // Acc: collecting samples; Hold: presenting a finished window downstream.
  typedef enum logic [0:0] {
    Acc  = 1'b0,
    Hold = 1'b1
  } state_e;

endpackage

// File: rtl/sum_window_acc.sv
// Sums a window of unsigned samples (length cfg_len, 0 = 2^LEN_W) and emits total and count.
// Optional feature: define SUM_WINDOW_ACC_MAX_EN to add out_max, the largest sample of the window.
module sum_window_acc
  import sum_window_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned LEN_W  = DefaultLenW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+LEN_W:0]   out_sum,
  output logic [LEN_W:0]          out_count
`ifdef SUM_WINDOW_ACC_MAX_EN
  ,
  output logic [DATA_W-1:0]       out_max
`endif
);

  localparam int unsigned AccW = DATA_W + LEN_W + 1;
  localparam int unsigned CntW = LEN_W + 1;
  localparam logic [CntW-1:0] MaxLen = {1'b1, {LEN_W{1'b0}}};

  state_e          state_q, state_d;
  logic [AccW-1:0] acc_q, acc_d, acc_inc;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CntW-1:0] len_q, len_d;
  logic [CntW-1:0] cfg_len_dec, win_len;
  logic [AccW-1:0] out_sum_q, out_sum_d;
  logic [CntW-1:0] out_count_q, out_count_d;
  logic            accept, emit, handshake;

  assign accept      = (state_q == Acc) && in_valid;
  assign handshake   = (state_q == Hold) && out_ready;
  assign acc_inc     = acc_q + AccW'(in_data);
  assign cnt_inc     = cnt_q + CntW'(1);
  assign cfg_len_dec = (cfg_len == '0) ? MaxLen : {1'b0, cfg_len};
  // The first sample of a window uses the live cfg_len; later samples use the latched copy.
  assign win_len     = (cnt_q == '0) ? cfg_len_dec : len_q;

  assign in_ready  = (state_q == Acc);
  assign out_valid = (state_q == Hold);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    emit        = 1'b0;
    unique case (state_q)
      Acc: begin
        if (accept) begin
          acc_d = acc_inc;
          cnt_d = cnt_inc;
          if (cnt_q == '0) begin
            len_d = cfg_len_dec;
          end
        end
        // A flush in the same cycle as a sample still closes the window with that sample in it.
        if ((accept && (cnt_inc == win_len)) || (flush && (cnt_d != '0))) begin
          state_d     = Hold;
          out_sum_d   = acc_d;
          out_count_d = cnt_d;
          emit        = 1'b1;
        end
      end
      Hold: begin
        if (out_ready) begin
          state_d = Acc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = Acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= Acc;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= MaxLen;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

`ifdef SUM_WINDOW_ACC_MAX_EN
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;

  always_comb begin
    max_d     = max_q;
    out_max_d = out_max_q;
    if (accept && (in_data > max_q)) begin
      max_d = in_data;
    end
    if (emit) begin
      out_max_d = max_d;
    end
    if (handshake) begin
      max_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q     <= '0;
      out_max_q <= '0;
    end else begin
      max_q     <= max_d;
      out_max_q <= out_max_d;
    end
  end

  assign out_max = out_max_q;
`endif

endmodule

// File: tb/tb_sum_window_acc.sv
// Self-checking bench for sum_window_acc: directed scenarios plus randomized traffic
// compared every cycle against a queue-based window model.
module tb_sum_window_acc;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [LW-1:0] cfg_len;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW+LW:0] out_sum;
  logic [LW:0]   out_count;
`ifdef SUM_WINDOW_ACC_MAX_EN
  logic [DW-1:0] out_max;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sum_window_acc #(
    .DATA_W(DW),
    .LEN_W (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cfg_len  (cfg_len),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
`ifdef SUM_WINDOW_ACC_MAX_EN
    ,
    .out_max  (out_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the open window is a queue of samples; outputs derive from it.
  bit  model_live = 0;
  bit  m_hold;
  int  win[$];
  int  m_len;
  int  exp_sum, exp_cnt, exp_max;

  always @(posedge clk) begin
    model_live = 1;
    if (rst) begin
      m_hold = 0;
      win.delete();
      m_len = 1 << LW;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        win.delete();
      end
    end else begin
      if (in_valid) begin
        if (win.size() == 0) m_len = (cfg_len == 0) ? (1 << LW) : int'(cfg_len);
        win.push_back(int'(in_data));
      end
      if (win.size() > 0 && (win.size() == m_len || flush)) begin
        m_hold  = 1;
        exp_sum = 0;
        exp_max = 0;
        foreach (win[i]) begin
          exp_sum += win[i];
          if (win[i] > exp_max) exp_max = win[i];
        end
        exp_cnt = win.size();
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("in_ready", in_ready, !m_hold);
      chk("out_valid", out_valid, m_hold);
      if (m_hold) begin
        chk("out_sum", out_sum, exp_sum);
        chk("out_count", out_count, exp_cnt);
`ifdef SUM_WINDOW_ACC_MAX_EN
        chk("out_max", out_max, exp_max);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int c);
    in_valid = 1'b1;
    in_data  = DW'(d);
    cfg_len  = LW'(c);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_len = '0; flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    rst = 1'b0;

    // Window of 4, back to back
    send(10, 4); send(20, 4); send(30, 4); send(40, 4);
    chk("w4_valid", out_valid, 1);
    chk("w4_sum", out_sum, 100);
    chk("w4_count", out_count, 4);
    step();
    chk("w4_ready_after", in_ready, 1);

    // Maximum window, all-ones samples
    for (int i = 0; i < 16; i++) send(255, 0);
    chk("w16_sum", out_sum, 4080);
    chk("w16_count", out_count, 16);
    step();

    // Partial window via flush, then flush on an empty window
    send(5, 8); send(7, 8);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid", out_valid, 1);
    chk("flush_sum", out_sum, 12);
    chk("flush_count", out_count, 2);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_empty_valid", out_valid, 0);

    // Back-pressure in Hold
    out_ready = 1'b0;
    send(1, 3); send(2, 3); send(3, 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'd99;
      step();
      chk("bp_sum", out_sum, 6);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    send(4, 3); send(4, 3); send(4, 3);
    chk("bp_next_sum", out_sum, 12);
    step();

    // Reset mid-window discards the partial result
    send(1, 4); send(1, 4);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) send(1, 4);
    chk("rst_next_sum", out_sum, 4);
    chk("rst_next_count", out_count, 4);
    step();

`ifdef SUM_WINDOW_ACC_MAX_EN
    send(9, 3); send(200, 3); send(3, 3);
    chk("max_out_max", out_max, 200);
    chk("max_out_sum", out_sum, 212);
    step();
`endif

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? 8'hff : DW'($urandom);
      cfg_len   = LW'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
